// File: rtl/crop_pkg.sv
// Shared helpers for the crop_fifo block: counter sizing and the window test.
package crop_pkg;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when position (r, c) falls inside the nr x nc window anchored at (y1, x1).
  function automatic logic in_window(
    input int r,
    input int c,
    input int y1,
    input int x1,
    input int nr,
    input int nc
  );
    return (r >= y1) && (r < y1 + nr) && (c >= x1) && (c < x1 + nc);
  endfunction

endpackage

// File: rtl/crop_fifo_sync_fifo.sv
// Show-ahead single-clock FIFO: the head entry is visible on rd_data whenever
// the FIFO is non-empty, and a pop simply advances the read pointer.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW   = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);

  // Guard the strobes so a misbehaving caller cannot overrun or underrun.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head entry is driven straight from storage; zero when nothing is held.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Next-state for pointers (wrapping at DEPTH, which need not be a power of 2) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; storage contents are left alone on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/crop_fifo.sv
// Streaming region-of-interest crop: tracks the raster position of each
// accepted pixel, keeps only those inside the window, and buffers them in a
// show-ahead FIFO that drains to a stallable consumer.
module crop_fifo
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int OUT_ROWS        = 3,
  parameter int OUT_COLS        = 3,
  parameter int Y_1             = 2,
  parameter int X_1             = 2,
  parameter int FIFO_DEPTH      = OUT_ROWS * OUT_COLS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int RW = cnt_w(IN_ROWS);
  localparam int CW = cnt_w(IN_COLS);

  // Reject window placements that fall off the frame, and FIFOs too small to be useful.
  if (Y_1 + OUT_ROWS > IN_ROWS) begin : g_bad_rows
    $error("crop_fifo: crop window extends past the last input row");
  end
  if (X_1 + OUT_COLS > IN_COLS) begin : g_bad_cols
    $error("crop_fifo: crop window extends past the last input column");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("crop_fifo: FIFO_DEPTH must be at least 2");
  end

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          in_fire;
  logic          keep;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  // Discarded pixels stall too: readiness depends only on FIFO space.
  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign in_fire   = in_valid & in_ready;
  assign keep      = in_window(int'(row_q), int'(col_q), Y_1, X_1, OUT_ROWS, OUT_COLS);
  assign push      = in_fire & keep;
  assign pop       = out_valid & out_ready;

  // Raster position advance: column fastest, both wrap at the end of a frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (in_fire) begin
      if (col_q == CW'(IN_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IN_ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers; reset restarts at the top-left of a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  sync_fifo #(
    .WIDTH (PIXEL_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (pixel_in),
    .pop     (pop),
    .rd_data (pixel_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_crop_fifo.sv
// Scoreboard bench for crop_fifo: stimulus pushes expected kept pixels into a
// queue, independent monitors pop and compare on every output transfer.
module tb_crop_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] pixel_in,  pixel_in2;
  logic       in_valid,  in_valid2;
  logic       in_ready,  in_ready2;
  logic [7:0] pixel_out, pixel_out2;
  logic       out_valid, out_valid2;
  logic       out_ready, out_ready2;

  int n_checks = 0;
  int n_fail   = 0;
  int q1[$];
  int q2[$];
  int idx1 = 0;
  int idx2 = 0;
  int acc_total = 0;
  int out_cnt1 = 0;
  int out_cnt2 = 0;

  // Hand-derived list of raster indices inside the 3x3 window at (2,2) of a 9x9 frame.
  int kept_list [9] = '{20, 21, 22, 29, 30, 31, 38, 39, 40};

  crop_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (pixel_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel_out (pixel_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  crop_fifo #(.FIFO_DEPTH(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (pixel_in2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .pixel_out (pixel_out2),
    .out_valid (out_valid2),
    .out_ready (out_ready2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_kept(input int idx);
    for (int i = 0; i < 9; i++) begin
      if (kept_list[i] == idx) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One cycle of stimulus on dut; outputs seen afterwards reflect the previous cycle's transfers.
  task automatic drive1(input bit v, input bit r, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    pixel_in  = 8'(idx1);
    acc = v && in_ready;
    if (acc) begin
      if (is_kept(idx1)) q1.push_back(idx1);
      idx1 = (idx1 == 80) ? 0 : idx1 + 1;
      acc_total++;
    end
  endtask

  task automatic drive2(input bit v, input bit r, output bit acc);
    @(posedge clk);
    #1;
    in_valid2  = v;
    out_ready2 = r;
    pixel_in2  = 8'(idx2);
    acc = v && in_ready2;
    if (acc) begin
      if (is_kept(idx2)) q2.push_back(idx2);
      idx2 = (idx2 == 80) ? 0 : idx2 + 1;
    end
  endtask

  task automatic drain1(input string name);
    bit acc;
    int n = 0;
    while ((q1.size() != 0 || out_valid) && n < 100) begin
      drive1(1'b0, 1'b1, acc);
      n++;
    end
    check({name, "_drain_timeout"}, (n < 100) ? 1 : 0, 1);
  endtask

  // Monitor for the default-depth instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        out_cnt1++;
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut1_unexpected_out: got %0d, expected no output", pixel_out);
        end else begin
          $display("dut1 out pixel=%0d", pixel_out);
          check("dut1_out_data", int'(pixel_out), q1.pop_front());
        end
      end
      if (!out_valid) check("dut1_idle_zero", int'(pixel_out), 0);
    end
  end

  // Monitor for the depth-2 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid2 && out_ready2) begin
        out_cnt2++;
        if (q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut2_unexpected_out: got %0d, expected no output", pixel_out2);
        end else begin
          $display("dut2 out pixel=%0d", pixel_out2);
          check("dut2_out_data", int'(pixel_out2), q2.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    int n;
    int base;
    int first_stall;

    reset = 1'b1;
    in_valid = 1'b0;  out_ready = 1'b0;  pixel_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; pixel_in2 = '0;

    // Reset values, during reset and the cycle after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_pixel_out", int'(pixel_out), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_pixel_out", int'(pixel_out), 0);

    // Stall downstream: FIFO fills after index 40, stalling the rest of the frame.
    first_stall = -1;
    acc_total = 0;
    for (int i = 0; i < 200; i++) begin
      bit prev20;
      prev20 = (idx1 == 21) && (acc_total == 21);
      drive1(1'b1, 1'b0, acc);
      if (prev20 && i == 21) begin
        check("latency_out_valid", int'(out_valid), 1);
        check("latency_pixel", int'(pixel_out), 20);
      end
      if (!acc && first_stall < 0) first_stall = acc_total;
    end
    check("stall_accept_count", acc_total, 41);
    check("stall_point", first_stall, 41);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_out_valid", int'(out_valid), 1);
    check("stall_head", int'(pixel_out), 20);

    // Drain the nine kept pixels back to back.
    base = out_cnt1;
    for (int i = 0; i < 11; i++) begin
      drive1(1'b0, 1'b1, acc);
      check("drain_out_valid", int'(out_valid), (i < 9) ? 1 : 0);
    end
    check("drain_count", out_cnt1 - base, 9);

    // Finish the frame; nothing else in it is kept.
    n = 0;
    while (idx1 != 0 && n < 200) begin
      drive1(1'b1, 1'b1, acc);
      n++;
    end
    check("frame_end_reached", idx1, 0);
    drain1("frame1");

    // Three frames with random handshakes on both sides.
    base = out_cnt1;
    acc_total = 0;
    n = 0;
    while (acc_total < 243 && n < 3000) begin
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      n++;
    end
    check("rand_accept_count", acc_total, 243);
    drain1("rand");
    check("rand_out_count", out_cnt1 - base, 27);

    // Reset mid-frame after 45 pixels, then one clean frame.
    acc_total = 0;
    n = 0;
    while (acc_total < 45 && n < 500) begin
      drive1(1'b1, 1'b1, acc);
      n++;
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q1.delete();
    idx1 = 0;
    @(posedge clk); #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = out_cnt1;
    acc_total = 0;
    n = 0;
    while (acc_total < 81 && n < 500) begin
      drive1(1'b1, 1'b1, acc);
      n++;
    end
    drain1("after_reset");
    check("after_reset_out_count", out_cnt1 - base, 9);
    in_valid = 1'b0; out_ready = 1'b0;

    // Depth-2 instance: bring count to 1 with index 20, then push and pop together.
    n = 0;
    while (idx2 < 21 && n < 100) begin
      drive2(1'b1, 1'b0, acc);
      n++;
    end
    drive2(1'b1, 1'b1, acc);
    check("d2_count1_out_valid", int'(out_valid2), 1);
    check("d2_count1_in_ready", int'(in_ready2), 1);
    check("d2_count1_accept", int'(acc), 1);
    drive2(1'b1, 1'b0, acc);
    check("d2_pushpop_out_valid", int'(out_valid2), 1);
    check("d2_pushpop_in_ready", int'(in_ready2), 1);
    check("d2_pushpop_head", int'(pixel_out2), 21);

    // Rest of the frame with out_ready toggling every cycle.
    n = 0;
    while (idx2 != 0 && n < 500) begin
      drive2(1'b1, (n % 2) == 0, acc);
      n++;
    end
    check("d2_frame_end", idx2, 0);
    n = 0;
    while ((q2.size() != 0 || out_valid2) && n < 100) begin
      drive2(1'b0, 1'b1, acc);
      n++;
    end
    check("d2_drain_timeout", (n < 100) ? 1 : 0, 1);
    check("d2_out_count", out_cnt2, 9);

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
